// File: rtl/truth_table_checker.sv
// Response checker: compares sampled DUT outputs against EXP_TABLE, tracks code coverage and errors.
// Optional watchdog enabled by defining macro CHK_TIMEOUT_EN.
module truth_table_checker #(
   parameter int unsigned             N_IN        = 4,
   parameter logic [(2**N_IN)-1:0]    EXP_TABLE   = 16'hF888,
   parameter int unsigned             CNT_W       = 8,
   parameter int unsigned             TIMEOUT_CYC = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     vec_valid,
   input  logic [N_IN-1:0]          vec_in,
   input  logic                     dut_out,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [CNT_W-1:0]         err_count,
   output logic [(2**N_IN)-1:0]     cov_map,
   output logic                     first_fail_valid,
   output logic [N_IN-1:0]          first_fail_vec,
   output logic                     timeout
);

   localparam int unsigned DEPTH = 2**N_IN;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state, state_nxt;
   logic                mismatch;
   logic                timeout_hit;
   logic                busy_nxt, done_nxt, pass_nxt;
   logic [CNT_W-1:0]    err_nxt;
   logic [DEPTH-1:0]    cov_nxt;
   logic                ffv_nxt;
   logic [N_IN-1:0]     ffvec_nxt;

`ifdef CHK_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] wd_cnt;

   // Idle-cycle watchdog; the TIMEOUT_CYC-th consecutive idle edge in RUN fires it
   assign timeout_hit = (state == RUN) && !start && !vec_valid &&
                        (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         if (start || vec_valid || (state != RUN)) wd_cnt <= '0;
         else                                       wd_cnt <= wd_cnt + WD_W'(1);
         if (start)            timeout <= 1'b0;
         else if (timeout_hit) timeout <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout     = 1'b0;
`endif

   // Result datapath: start clears and wins over a same-edge sample
   always_comb begin
      err_nxt   = err_count;
      cov_nxt   = cov_map;
      ffv_nxt   = first_fail_valid;
      ffvec_nxt = first_fail_vec;
      mismatch  = (dut_out != EXP_TABLE[vec_in]);
      if (start) begin
         err_nxt   = '0;
         cov_nxt   = '0;
         ffv_nxt   = 1'b0;
         ffvec_nxt = '0;
      end else if ((state == RUN) && vec_valid) begin
         cov_nxt[vec_in] = 1'b1;
         if (mismatch && (err_count != '1)) err_nxt = err_count + CNT_W'(1);
         if (mismatch && !first_fail_valid) begin
            ffv_nxt   = 1'b1;
            ffvec_nxt = vec_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            if (start)                         state_nxt = RUN;
            else if (vec_valid && (&cov_nxt))  state_nxt = DONE;
            else if (timeout_hit)              state_nxt = DONE;
         end
         DONE: if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // A run only passes if it completed coverage, so a watchdog exit never passes
   always_comb begin
      busy_nxt = (state_nxt == RUN);
      done_nxt = (state_nxt == DONE);
      pass_nxt = (state_nxt == DONE) && (err_nxt == '0) && (&cov_nxt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_count        <= '0;
         cov_map          <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
      end else begin
         busy             <= busy_nxt;
         done             <= done_nxt;
         pass             <= pass_nxt;
         err_count        <= err_nxt;
         cov_map          <= cov_nxt;
         first_fail_valid <= ffv_nxt;
         first_fail_vec   <= ffvec_nxt;
      end
   end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: default instance plus a CNT_W=2 instance sharing stimulus.
module tb_truth_table_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        vec_valid = 1'b0;
   logic [3:0]  vec_in = '0;
   logic        dut_out = 1'b0;

   logic        busy, done, pass, first_fail_valid, timeout;
   logic [7:0]  err_count;
   logic [15:0] cov_map;
   logic [3:0]  first_fail_vec;

   logic        s_busy, s_done, s_pass, s_ffv, s_timeout;
   logic [1:0]  s_err;
   logic [15:0] s_cov;
   logic [3:0]  s_ffvec;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   truth_table_checker #(.N_IN(4), .EXP_TABLE(16'hF888), .CNT_W(8), .TIMEOUT_CYC(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec_in(vec_in),
      .dut_out(dut_out), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .cov_map(cov_map), .first_fail_valid(first_fail_valid), .first_fail_vec(first_fail_vec),
      .timeout(timeout));

   truth_table_checker #(.N_IN(4), .EXP_TABLE(16'hF888), .CNT_W(2), .TIMEOUT_CYC(8)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec_in(vec_in),
      .dut_out(dut_out), .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
      .cov_map(s_cov), .first_fail_valid(s_ffv), .first_fail_vec(s_ffvec),
      .timeout(s_timeout));

   // Reference function f=(a&b)|(c&d), vec={a,b,c,d}
   function automatic logic f_ref(input logic [3:0] c);
      return (c[3] & c[2]) | (c[1] & c[0]);
   endfunction

   task automatic send(input logic [3:0] code, input logic val);
      vec_valid = 1'b1; vec_in = code; dut_out = val;
      @(posedge clk); #1;
      vec_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({busy, done, pass, first_fail_valid, timeout} !== 5'b0) $display("FAIL reset_flags got=%b exp=00000", {busy, done, pass, first_fail_valid, timeout});
      else passed++;
      total++;
      if ({err_count, cov_map, first_fail_vec} !== 28'h0) $display("FAIL reset_data got err=%0d cov=%h ffvec=%h exp 0", err_count, cov_map, first_fail_vec);
      else passed++;
      @(posedge clk); #1; rst_n = 1'b1;
      idle(1);
   endtask

   task automatic test_pass_sweep();
      pulse_start();
      total++;
      if ({busy, done} !== 2'b10) $display("FAIL start_busy got=%b exp=10", {busy, done});
      else passed++;
      for (int i = 0; i < 15; i++) send(4'(i), f_ref(4'(i)));
      total++;
      if ({busy, done, cov_map} !== {2'b10, 16'h7FFF}) $display("FAIL sweep_pre15 got busy/done=%b cov=%h exp 10 7fff", {busy, done}, cov_map);
      else passed++;
      send(4'hF, f_ref(4'hF));
      total++;
      if ({busy, done, pass, first_fail_valid} !== 4'b0110) $display("FAIL sweep_done got=%b exp=0110", {busy, done, pass, first_fail_valid});
      else passed++;
      total++;
      if ({err_count, cov_map} !== {8'd0, 16'hFFFF}) $display("FAIL sweep_data got err=%0d cov=%h exp 0 ffff", err_count, cov_map);
      else passed++;
      idle(2);
      total++;
      if ({done, pass, cov_map} !== {2'b11, 16'hFFFF}) $display("FAIL done_hold got=%b cov=%h exp 11 ffff", {done, pass}, cov_map);
      else passed++;
   endtask

   task automatic test_mismatch();
      pulse_start();
      total++;
      if ({busy, done, pass, err_count, cov_map} !== {3'b100, 8'd0, 16'h0}) $display("FAIL restart_clear got flags=%b err=%0d cov=%h", {busy, done, pass}, err_count, cov_map);
      else passed++;
      for (int i = 0; i < 16; i++) begin
         logic v;
         v = f_ref(4'(i));
         if (i == 12) v = 1'b0;
         if (i == 2)  v = 1'b1;
         send(4'(i), v);
      end
      total++;
      if ({done, pass, first_fail_valid, first_fail_vec} !== {3'b101, 4'h2}) $display("FAIL mism_flags got done/pass/ffv=%b ffvec=%h exp 101 2", {done, pass, first_fail_valid}, first_fail_vec);
      else passed++;
      total++;
      if (err_count !== 8'd2) $display("FAIL mism_count got=%0d exp=2", err_count);
      else passed++;
      total++;
      if (s_err !== 2'd2) $display("FAIL mism_count_w2 got=%0d exp=2", s_err);
      else passed++;
   endtask

   task automatic test_gaps_repeat();
      pulse_start();
      for (int i = 0; i < 15; i++) begin
         send(4'(i), f_ref(4'(i)));
         idle(3);
         if (i == 5) begin send(4'd5, f_ref(4'd5)); idle(3); end
      end
      total++;
      if ({busy, done, err_count, cov_map} !== {2'b10, 8'd0, 16'h7FFF}) $display("FAIL gaps_partial got flags=%b err=%0d cov=%h exp 10 0 7fff", {busy, done}, err_count, cov_map);
      else passed++;
      send(4'hF, f_ref(4'hF));
      total++;
      if ({busy, done, pass} !== 3'b011) $display("FAIL gaps_done got=%b exp=011", {busy, done, pass});
      else passed++;
   endtask

   task automatic test_saturation();
      pulse_start();
      for (int i = 0; i < 16; i++) send(4'(i), (i < 5) ? ~f_ref(4'(i)) : f_ref(4'(i)));
      total++;
      if (err_count !== 8'd5) $display("FAIL sat_wide got=%0d exp=5", err_count);
      else passed++;
      total++;
      if ({s_err, s_done, s_pass, s_ffvec} !== {2'd3, 2'b10, 4'h0}) $display("FAIL sat_narrow got err=%0d done/pass=%b ffvec=%h exp 3 10 0", s_err, {s_done, s_pass}, s_ffvec);
      else passed++;
   endtask

   task automatic test_reset_midrun();
      pulse_start();
      for (int i = 0; i < 7; i++) send(4'(i), (i == 1) ? ~f_ref(4'(i)) : f_ref(4'(i)));
      total++;
      if ({first_fail_valid, err_count, cov_map} !== {1'b1, 8'd1, 16'h007F}) $display("FAIL midrun_pre got ffv=%b err=%0d cov=%h exp 1 1 007f", first_fail_valid, err_count, cov_map);
      else passed++;
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy, done, pass, first_fail_valid, timeout, err_count, cov_map, first_fail_vec} !== 33'h0) $display("FAIL midrun_reset got busy=%b err=%0d cov=%h ffv=%b", busy, err_count, cov_map, first_fail_valid);
      else passed++;
      @(posedge clk); #1; rst_n = 1'b1;
      send(4'h3, 1'b0);
      total++;
      if ({busy, err_count, cov_map} !== 25'h0) $display("FAIL idle_ignore got busy=%b err=%0d cov=%h exp 0", busy, err_count, cov_map);
      else passed++;
   endtask

   task automatic test_start_coincident();
      pulse_start();
      send(4'h0, f_ref(4'h0));
      send(4'h1, f_ref(4'h1));
      start = 1'b1; vec_valid = 1'b1; vec_in = 4'h2; dut_out = ~f_ref(4'h2);
      @(posedge clk); #1;
      start = 1'b0; vec_valid = 1'b0;
      total++;
      if ({busy, first_fail_valid, err_count, cov_map} !== {2'b10, 8'd0, 16'h0}) $display("FAIL start_vs_valid got busy/ffv=%b err=%0d cov=%h exp 10 0 0", {busy, first_fail_valid}, err_count, cov_map);
      else passed++;
      for (int i = 15; i >= 0; i--) send(4'(i), f_ref(4'(i)));
      total++;
      if ({done, pass, err_count} !== {2'b11, 8'd0}) $display("FAIL reverse_sweep got done/pass=%b err=%0d exp 11 0", {done, pass}, err_count);
      else passed++;
   endtask

   task automatic test_timeout();
      pulse_start();
      send(4'h0, f_ref(4'h0));
      send(4'h1, f_ref(4'h1));
      send(4'h2, f_ref(4'h2));
      idle(7);
      total++;
      if ({busy, done, timeout} !== 3'b100) $display("FAIL wd_pre got=%b exp=100", {busy, done, timeout});
      else passed++;
      idle(1);
`ifdef CHK_TIMEOUT_EN
      total++;
      if ({busy, done, pass, timeout, cov_map} !== {4'b0101, 16'h0007}) $display("FAIL wd_fire got flags=%b cov=%h exp 0101 0007", {busy, done, pass, timeout}, cov_map);
      else passed++;
`else
      idle(4);
      total++;
      if ({busy, done, pass, timeout, cov_map} !== {4'b1000, 16'h0007}) $display("FAIL wd_absent got flags=%b cov=%h exp 1000 0007", {busy, done, pass, timeout}, cov_map);
      else passed++;
`endif
   endtask

   initial begin
      test_reset();
      test_pass_sweep();
      test_mismatch();
      test_gaps_repeat();
      test_saturation();
      test_reset_midrun();
      test_start_coincident();
      test_timeout();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
